// File: rtl/prim_gate_en_ctrl.sv
// prim_gate_en_ctrl: registered enable controller for a bank of AND-gate lanes.
// Latency: req_i to en_o is 1 cycle; en_o to ack_o is 1 more cycle; idle auto-close after IdleCycles.
// Backpressure: level req_i/busy_i hold the gate open; close_i forces a close and wins over both.
//
// Ports:
//   clk_i        - clock
//   rst_i        - synchronous active-high reset
//   req_i        - level request to open / keep open
//   lane_mask_i  - lanes to enable, sampled only when leaving CLOSED
//   busy_i       - downstream activity, keeps the gate open
//   close_i      - forced close, priority over req_i and busy_i
//   en_o         - registered lane enables to the AND gates
//   ack_o        - registered, high while the gate is fully open
//   state_o      - current FSM state (debug)
// Optional feature macro: PRIM_GATE_EN_CTRL_STATS_EN adds open_cnt_o / force_cnt_o
// (16-bit saturating counters of opens and forced closes).

module prim_gate_en_ctrl #(
  parameter int Width      = 1,
  parameter int IdleCycles = 16,
  parameter int CntW       = $clog2(IdleCycles + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [Width-1:0] lane_mask_i,
  input  logic             busy_i,
  input  logic             close_i,
  output logic [Width-1:0] en_o,
  output logic             ack_o,
`ifdef PRIM_GATE_EN_CTRL_STATS_EN
  output logic [15:0]      open_cnt_o,
  output logic [15:0]      force_cnt_o,
`endif
  output logic [1:0]       state_o
);

  localparam logic [1:0] ST_CLOSED  = 2'b00;
  localparam logic [1:0] ST_OPENING = 2'b01;
  localparam logic [1:0] ST_OPEN    = 2'b10;
  localparam logic [1:0] ST_CLOSING = 2'b11;

  localparam logic [CntW-1:0] IDLE_LOAD = CntW'(IdleCycles);
  localparam logic [CntW-1:0] CNT_ONE   = CntW'(1);

  logic [1:0]       r_state;
  logic [Width-1:0] r_mask;
  logic [CntW-1:0]  r_cnt;
  logic [Width-1:0] r_en;
  logic             r_ack;

  logic [1:0]       w_state_nxt;
  logic [Width-1:0] w_mask_nxt;
  logic [CntW-1:0]  w_cnt_nxt;
  logic             w_open_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLOSED: begin
        w_cnt_nxt = '0;
        if (req_i && !close_i) begin
          w_state_nxt = ST_OPENING;
          w_mask_nxt  = lane_mask_i;
        end
      end
      ST_OPENING: begin
        if (close_i) begin
          w_state_nxt = ST_CLOSING;
        end else begin
          w_state_nxt = ST_OPEN;
          w_cnt_nxt   = IDLE_LOAD;
        end
      end
      ST_OPEN: begin
        if (close_i) begin
          w_state_nxt = ST_CLOSING;
        end else if (req_i || busy_i) begin
          w_cnt_nxt = IDLE_LOAD;
        end else begin
          // Counter is >= 1 in OPEN; closing on the 1->0 step gives exactly IdleCycles idle cycles.
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            w_state_nxt = ST_CLOSING;
          end
        end
      end
      default: begin
        // CLOSING lasts one cycle and ignores req_i, guaranteeing a gap with en_o low.
        w_state_nxt = ST_CLOSED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with state_o.
  assign w_open_nxt = (w_state_nxt == ST_OPENING) || (w_state_nxt == ST_OPEN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_CLOSED;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_en    <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= w_open_nxt ? w_mask_nxt : '0;
      r_ack   <= (w_state_nxt == ST_OPEN);
    end
  end

  assign en_o    = r_en;
  assign ack_o   = r_ack;
  assign state_o = r_state;

`ifdef PRIM_GATE_EN_CTRL_STATS_EN
  logic [15:0] r_open_cnt;
  logic [15:0] r_force_cnt;
  logic        w_open_evt;
  logic        w_force_evt;

  assign w_open_evt  = (r_state == ST_CLOSED) && (w_state_nxt == ST_OPENING);
  assign w_force_evt = ((r_state == ST_OPENING) || (r_state == ST_OPEN)) && close_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_open_cnt  <= '0;
      r_force_cnt <= '0;
    end else begin
      if (w_open_evt && (r_open_cnt != 16'hFFFF)) begin
        r_open_cnt <= r_open_cnt + 16'd1;
      end
      if (w_force_evt && (r_force_cnt != 16'hFFFF)) begin
        r_force_cnt <= r_force_cnt + 16'd1;
      end
    end
  end

  assign open_cnt_o  = r_open_cnt;
  assign force_cnt_o = r_force_cnt;
`endif

endmodule
